// File: rtl/cpu_control_unit.sv
// Microcoded-style control unit: FETCH/DECODE/WAIT_IN/EXEC/HALT sequencer for an 8-bit ISA.
// Optional macro CPU_SINGLE_STEP_EN adds a step input that gates each FETCH.
//
// state   | meaning
// FETCH   | pc presented to ROM, no strobes
// DECODE  | ROM word captured into IR
// WAIT_IN | ADDIN waiting for ext_valid, B bus on ext_input
// EXEC    | one-cycle strobe decode of IR, pc update
// HALT    | terminal, halted=1, exit only by reset
module cpu_control_unit #(
    parameter logic [4:0] RESET_PC = 5'd0
) (
    input  logic       clk,
    input  logic       reset_n,
`ifdef CPU_SINGLE_STEP_EN
    input  logic       step,
`endif
    input  logic [7:0] instr,
    input  logic       ext_valid,
    output logic [4:0] pc,
    output logic [1:0] B_sel,
    output logic [1:0] alu_op,
    output logic       A_load,
    output logic       B_load,
    output logic       ext_ack,
    output logic       halted
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_WAIT_IN = 3'd2,
        S_EXEC    = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_ADDB  = 3'b001;
    localparam logic [2:0] OP_ADDIN = 3'b010;
    localparam logic [2:0] OP_SUBB  = 3'b011;
    localparam logic [2:0] OP_INC   = 3'b100;
    localparam logic [2:0] OP_CLR   = 3'b101;
    localparam logic [2:0] OP_MOVB  = 3'b110;
    localparam logic [2:0] OP_JMP   = 3'b111;

    state_t     state_q, state_d;
    logic [4:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [1:0] b_sel_q, b_sel_d;
    logic [1:0] alu_op_q, alu_op_d;
    logic       a_load_q, a_load_d;
    logic       b_load_q, b_load_d;
    logic       ext_ack_q, ext_ack_d;
    logic       halted_q, halted_d;

    // Output bundle {b_sel, alu_op, a_load, b_load, ext_ack, halted} for a given state/IR.
    function automatic logic [7:0] decode_out(input state_t s, input logic [7:0] ir);
        logic [7:0] o;
        o = 8'h00;
        case (s)
            S_WAIT_IN: o = 8'b01_00_0000;
            S_HALT:    o = 8'b00_00_0001;
            S_EXEC: begin
                case (ir[7:5])
                    OP_ADDB:  o = 8'b00_00_1000;
                    OP_ADDIN: o = 8'b01_00_1010;
                    OP_SUBB:  o = 8'b00_01_1000;
                    OP_INC:   o = 8'b11_00_1000;
                    OP_CLR:   o = 8'b10_10_1000;
                    OP_MOVB:  o = 8'b00_00_0100;
                    default:  o = 8'h00;
                endcase
            end
            default:   o = 8'h00;
        endcase
        return o;
    endfunction

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            S_FETCH: begin
`ifdef CPU_SINGLE_STEP_EN
                if (step) state_d = S_DECODE;
`else
                state_d = S_DECODE;
`endif
            end
            S_DECODE: begin
                ir_d    = instr;
                state_d = (instr[7:5] == OP_ADDIN) ? S_WAIT_IN : S_EXEC;
            end
            S_WAIT_IN: begin
                if (ext_valid) state_d = S_EXEC;
            end
            S_EXEC: begin
                if (ir_q == 8'hFF) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                    pc_d    = (ir_q[7:5] == OP_JMP) ? ir_q[4:0] : pc_q + 5'd1;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
        // Outputs are registered: precompute what the next state will present.
        {b_sel_d, alu_op_d, a_load_d, b_load_d, ext_ack_d, halted_d} = decode_out(state_d, ir_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= 8'h00;
            b_sel_q   <= 2'b00;
            alu_op_q  <= 2'b00;
            a_load_q  <= 1'b0;
            b_load_q  <= 1'b0;
            ext_ack_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            b_sel_q   <= b_sel_d;
            alu_op_q  <= alu_op_d;
            a_load_q  <= a_load_d;
            b_load_q  <= b_load_d;
            ext_ack_q <= ext_ack_d;
            halted_q  <= halted_d;
        end
    end

    assign pc      = pc_q;
    assign B_sel   = b_sel_q;
    assign alu_op  = alu_op_q;
    assign A_load  = a_load_q;
    assign B_load  = b_load_q;
    assign ext_ack = ext_ack_q;
    assign halted  = halted_q;

endmodule

// File: doc/cpu_control_unit.md
CPU_CONTROL_UNIT -- requirements
Module: cpu_control_unit

Interface
REQ-001 Parameter: RESET_PC, 5'd0, program counter value loaded on reset.
REQ-002 clk  input  1  single system clock, all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 instr  input  8  instruction word from synchronous program ROM, valid one cycle after pc changes.
REQ-005 ext_valid  input  1  external 6-bit input data present on ext_input bus.
REQ-006 pc  output  5  program counter, ROM address.
REQ-007 B_sel  output  2  B-bus source select (00 B_reg, 01 ext_input zero-extended, 10 constant 0, 11 constant 1).
REQ-008 alu_op  output  2  ALU operation (00 ADD, 01 SUB, 10 PASS_B, 11 reserved, never driven).
REQ-009 A_load  output  1  one-cycle strobe, A register captures ALU result.
REQ-010 B_load  output  1  one-cycle strobe, B register captures A register.
REQ-011 ext_ack  output  1  one-cycle strobe, ext_input consumed.
REQ-012 halted  output  1  high while in HALT.

Function
REQ-013 States: FETCH, DECODE, WAIT_IN, EXEC, HALT; 3-bit registered state.
REQ-014 FETCH: pc presented, no strobes; next state DECODE.
REQ-015 DECODE: IR <= instr at end of cycle; next WAIT_IN if opcode 010, else EXEC.
REQ-016 WAIT_IN: B_sel=01; stay while ext_valid=0; go to EXEC on rising edge where ext_valid=1.
REQ-017 Opcode = IR[7:5], address = IR[4:0]; decode in EXEC: 000 NOP; 001 ADDB (B_sel=00, ADD, A_load); 010 ADDIN (B_sel=01, ADD, A_load, ext_ack); 011 SUBB (B_sel=00, SUB, A_load); 100 INC (B_sel=11, ADD, A_load); 101 CLR (B_sel=10, PASS_B, A_load); 110 MOVB (B_load); 111 JMP to address, except address 11111 = HLT.
REQ-018 EXEC lasts exactly one cycle; strobes high only in EXEC; next state FETCH, or HALT for HLT.
REQ-019 pc update at end of EXEC: JMP pc <= address; HLT pc unchanged; all others pc <= pc+1 modulo 32 (31 wraps to 0).
REQ-020 Outside EXEC and WAIT_IN: B_sel=00, alu_op=00, all strobes 0.
REQ-021 All outputs decoded from registered state and IR only; no combinational input-to-output path.
REQ-022 Latency: 3 cycles per instruction; ADDIN 3 + N cycles, N>=1 cycles spent in WAIT_IN.
REQ-023 HALT is terminal: halted=1, pc frozen, no strobes; exit only by reset.
REQ-024 ext_valid ignored in all states except WAIT_IN; ext_ack never asserted without a WAIT_IN->EXEC transition.

Reset
REQ-025 reset_n low asynchronously forces state FETCH, pc=RESET_PC, IR=8'h00, B_sel=00, alu_op=00, A_load=B_load=ext_ack=halted=0.
REQ-026 Reset asserted mid-instruction (incl. WAIT_IN or EXEC) aborts it with no further strobes; first FETCH follows the first rising edge after deassertion.

Configuration
REQ-027 Macro CPU_SINGLE_STEP_EN: defined adds input step (1 bit); FETCH holds (pc stable) until step=1 sampled, then proceeds to DECODE; one step pulse = one instruction.
REQ-028 Without CPU_SINGLE_STEP_EN: no step port; FETCH always advances after one cycle.

Verification
REQ-029 Reset release, ROM {0:8'h20 ADDB, 1:8'h80 INC} -> pc 0,0,0,1; A_load high in cycle 3 with B_sel=00, alu_op=00; then B_sel=11.
REQ-030 ADDIN (8'h40), ext_valid raised 4 cycles after WAIT_IN entry -> exactly one ext_ack, coincident with A_load, B_sel=01, in cycle after ext_valid sampled.
REQ-031 JMP 8'hE5 at pc=3 -> next FETCH pc=5; NOP at pc=31 -> next pc=0.
REQ-032 HLT 8'hFF -> halted=1 from following cycle, pc held, no strobes for 20 cycles with ext_valid toggling.
REQ-033 reset_n pulsed low during WAIT_IN -> all outputs at reset values immediately, no ext_ack, restart at pc=RESET_PC.
REQ-034 With CPU_SINGLE_STEP_EN, step low 10 cycles -> pc=0 held, no strobes; one step pulse -> exactly one instruction executed.
